// File: rtl/fp_sqrt128_arb.sv
// fp_sqrt128_arb: round-robin arbiter sharing one iterative 128-bit FP square-root core among NREQ requesters.
// Define FP_SQRT_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (qNaN + rsp_err abort after TMO cycles).
module fp_sqrt128_arb #(
  parameter int NREQ   = 4,
  parameter int MINLAT = 4,
  parameter int TMO    = 255,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*128-1:0] req_a,
  input  logic [NREQ*3-1:0]   req_rm,
  output logic [NREQ-1:0]     gnt,
  output logic                sq_ld,
  output logic [127:0]        sq_a,
  output logic [2:0]          sq_rm,
  input  logic                sq_done,
  input  logic [127:0]        sq_o,
  input  logic                sq_inf,
  input  logic                sq_neg,
  output logic                rsp_vld,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_o,
  output logic                rsp_inf,
  output logic                rsp_neg,
  output logic                rsp_err,
  input  logic                rsp_rdy,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

`ifdef FP_SQRT_ARB_TIMEOUT_EN
  localparam bit           TIMEOUT_EN = 1'b1;
  localparam logic [127:0] QNAN       = 128'h7FFF_8000_0000_0000_0000_0000_0000_0000;
`else
  localparam bit           TIMEOUT_EN = 1'b0;
`endif
  localparam logic [7:0] MINLAT_C = 8'(MINLAT);
  localparam logic [7:0] TMO_C    = 8'(TMO);
  // The latency counter only needs to reach the largest threshold it is compared against.
  localparam logic [7:0] SAT_C    = TIMEOUT_EN ? TMO_C : MINLAT_C;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [127:0]   a_q, a_d;
  logic [2:0]     rm_q, rm_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           rsp_vld_q, rsp_vld_d;
  logic [127:0]   rsp_o_q, rsp_o_d;
  logic           rsp_inf_q, rsp_inf_d;
  logic           rsp_neg_q, rsp_neg_d;
`ifdef FP_SQRT_ARB_TIMEOUT_EN
  logic           rsp_err_q, rsp_err_d;
`endif

  logic           found;
  logic [IDW-1:0] sel_id;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel_id = IDW'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign gnt[gi] = (state_q == IDLE) && found && !rst && (sel_id == IDW'(gi));
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    a_d       = a_q;
    rm_d      = rm_q;
    cnt_d     = cnt_q;
    rsp_vld_d = rsp_vld_q;
    rsp_o_d   = rsp_o_q;
    rsp_inf_d = rsp_inf_q;
    rsp_neg_d = rsp_neg_q;
`ifdef FP_SQRT_ARB_TIMEOUT_EN
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = sel_id;
          a_d     = req_a[int'(sel_id)*128 +: 128];
          rm_d    = req_rm[int'(sel_id)*3 +: 3];
          rr_d    = (sel_id == IDW'(NREQ-1)) ? '0 : sel_id + IDW'(1);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done seen before MINLAT may be the level left over from the previous operation.
        if (sq_done && (cnt_q >= MINLAT_C)) begin
          rsp_o_d   = sq_o;
          rsp_inf_d = sq_inf;
          rsp_neg_d = sq_neg;
          rsp_vld_d = 1'b1;
`ifdef FP_SQRT_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          state_d   = RESP;
        end
`ifdef FP_SQRT_ARB_TIMEOUT_EN
        else if (cnt_q >= TMO_C) begin
          rsp_o_d   = QNAN;
          rsp_inf_d = 1'b0;
          rsp_neg_d = 1'b0;
          rsp_err_d = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end
`endif
        else if (cnt_q < SAT_C) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      a_q       <= '0;
      rm_q      <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_o_q   <= '0;
      rsp_inf_q <= 1'b0;
      rsp_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      rm_q      <= rm_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_o_q   <= rsp_o_d;
      rsp_inf_q <= rsp_inf_d;
      rsp_neg_q <= rsp_neg_d;
    end
  end

`ifdef FP_SQRT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign sq_ld   = (state_q == LAUNCH);
  assign sq_a    = a_q;
  assign sq_rm   = rm_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = id_q;
  assign rsp_o   = rsp_o_q;
  assign rsp_inf = rsp_inf_q;
  assign rsp_neg = rsp_neg_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_fp_sqrt128_arb.sv
// Testbench for fp_sqrt128_arb: behavioural sqrt-core stand-in plus a round-robin / latency reference model.
module tb_fp_sqrt128_arb;
  localparam int NREQ   = 4;
  localparam int MINLAT = 4;
  localparam int TMO    = 255;
  localparam int IDW    = $clog2(NREQ);
  localparam logic [127:0] FOUR  = 128'h4001_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] TWO   = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] QNAN  = 128'h7FFF_8000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] STALE = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*128-1:0] req_a;
  logic [NREQ*3-1:0]   req_rm;
  logic [NREQ-1:0]     gnt;
  logic                sq_ld;
  logic [127:0]        sq_a;
  logic [2:0]          sq_rm;
  logic                sq_done;
  logic [127:0]        sq_o;
  logic                sq_inf;
  logic                sq_neg;
  logic                rsp_vld;
  logic [IDW-1:0]      rsp_id;
  logic [127:0]        rsp_o;
  logic                rsp_inf;
  logic                rsp_neg;
  logic                rsp_err;
  logic                rsp_rdy;
  logic                busy;

  int compared   = 0;
  int mismatched = 0;
  int rr_model   = 0;

  always #5 clk = ~clk;

  fp_sqrt128_arb #(.NREQ(NREQ), .MINLAT(MINLAT), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_rm(req_rm), .gnt(gnt),
    .sq_ld(sq_ld), .sq_a(sq_a), .sq_rm(sq_rm), .sq_done(sq_done), .sq_o(sq_o),
    .sq_inf(sq_inf), .sq_neg(sq_neg), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_o(rsp_o),
    .rsp_inf(rsp_inf), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .rsp_rdy(rsp_rdy), .busy(busy)
  );

  // Stand-in core result: true sqrt for 4.0, otherwise an arbitrary reversible scramble.
  function automatic logic [127:0] core_result(input logic [127:0] a);
    if (a == FOUR) return TWO;
    return {a[63:0], a[127:64]} ^ 128'h5A5A_0F0F_3C3C_A5A5_1234_5678_9ABC_DEF0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Core model: done level rises core_delay cycles after the launch and stays high;
  // optionally the previous done level lingers (with stale data) for core_stale_len cycles.
  logic [127:0] core_op;
  int           core_age;
  bit           core_active;
  int           core_delay     = 3;
  bit           core_stale     = 1'b0;
  int           core_stale_len = 0;
  bit           core_stuck0    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      core_active <= 1'b0;
      core_age    <= 0;
    end else if (sq_ld) begin
      core_active <= 1'b1;
      core_age    <= 0;
      core_op     <= sq_a;
    end else if (core_active && core_age < 1000) begin
      core_age <= core_age + 1;
    end
  end

  always_comb begin
    sq_done = 1'b0;
    sq_o    = STALE;
    sq_inf  = 1'b0;
    sq_neg  = 1'b0;
    if (core_active && !core_stuck0) begin
      if (core_age >= core_delay) begin
        sq_done = 1'b1;
        sq_o    = core_result(core_op);
        sq_inf  = core_op[0];
        sq_neg  = core_op[127];
      end else if (core_stale && core_age < core_stale_len) begin
        sq_done = 1'b1;
      end
    end
  end

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*128 +: 128] = rand128();
      req_rm[i*3 +: 3]    = 3'($urandom_range(0, 7));
    end
  endtask

  // One full transaction, entered at the negedge of an IDLE cycle with req already driven.
  task automatic serve_one(input int hold, input bit expect_tmo);
    int             exp_id, lat, exp_lat;
    logic [NREQ-1:0] exp_gnt;
    logic [127:0]   exp_a, exp_o, held_o;
    logic [2:0]     exp_rm;
    logic           exp_inf, exp_neg, exp_err;
    logic [IDW-1:0] held_id;
    bit             bad;
    rsp_rdy = (hold == 0);
    #1;
    exp_id = -1;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (rr_model + i) % NREQ;
      if (exp_id < 0 && req[j]) exp_id = j;
    end
    if (exp_id < 0) begin
      compared++; mismatched++;
      $display("FAIL serve_setup: no request pending, gnt=%b required a pending request", gnt);
      return;
    end
    exp_gnt = '0;
    exp_gnt[exp_id] = 1'b1;
    compared++;
    if (gnt !== exp_gnt) begin
      mismatched++;
      $display("FAIL grant: gnt=%b required %b (req=%b rr=%0d)", gnt, exp_gnt, req, rr_model);
    end
    exp_a    = req_a[exp_id*128 +: 128];
    exp_rm   = req_rm[exp_id*3 +: 3];
    rr_model = (exp_id + 1) % NREQ;
    if (expect_tmo) begin
      exp_o = QNAN; exp_inf = 1'b0; exp_neg = 1'b0; exp_err = 1'b1;
      exp_lat = TMO + 3;
    end else begin
      exp_o = core_result(exp_a); exp_inf = exp_a[0]; exp_neg = exp_a[127]; exp_err = 1'b0;
      exp_lat = 3 + ((core_delay > MINLAT) ? core_delay : MINLAT);
    end

    @(negedge clk);
    lat = 1;
    compared++;
    if (sq_ld !== 1'b1 || sq_a !== exp_a || sq_rm !== exp_rm || gnt !== '0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL launch: sq_ld=%b sq_a=%h sq_rm=%0d gnt=%b busy=%b required 1 %h %0d 0 1",
               sq_ld, sq_a, sq_rm, gnt, busy, exp_a, exp_rm);
    end
    bad = 1'b0;
    while (rsp_vld !== 1'b1 && lat < 700) begin
      @(negedge clk);
      lat++;
      if (gnt !== '0 || busy !== 1'b1 || sq_ld !== 1'b0 || sq_a !== exp_a) bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL wait_phase: gnt/sq_ld/sq_a/busy disturbed while busy, required gnt=0 sq_ld=0 sq_a=%h", exp_a);
    end
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("FAIL latency: rsp_vld after %0d cycles, required %0d", lat, exp_lat);
    end
    compared++;
    if (rsp_id !== exp_id[IDW-1:0]) begin
      mismatched++;
      $display("FAIL rsp_id: got %0d required %0d", rsp_id, exp_id);
    end
    compared++;
    if (rsp_o !== exp_o) begin
      mismatched++;
      $display("FAIL rsp_o: got %h required %h", rsp_o, exp_o);
    end
    compared++;
    if ({rsp_inf, rsp_neg, rsp_err} !== {exp_inf, exp_neg, exp_err}) begin
      mismatched++;
      $display("FAIL rsp_flags: inf/neg/err=%b%b%b required %b%b%b",
               rsp_inf, rsp_neg, rsp_err, exp_inf, exp_neg, exp_err);
    end
    $display("txn id=%0d op=%h rsp=%h err=%0d lat=%0d hold=%0d", exp_id, exp_a, rsp_o, rsp_err, lat, hold);

    held_o  = rsp_o;
    held_id = rsp_id;
    bad     = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_vld !== 1'b1 || rsp_o !== held_o || rsp_id !== held_id || gnt !== '0 || busy !== 1'b1) bad = 1'b1;
    end
    if (hold > 0) begin
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL hold_stable: response changed or grant issued during %0d-cycle stall", hold);
      end
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    compared++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL handshake: rsp_vld=%b busy=%b required 0 0", rsp_vld, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rsp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (gnt !== '0 || sq_ld !== 1'b0 || sq_a !== '0 || sq_rm !== '0 || rsp_vld !== 1'b0 || rsp_id !== '0 ||
        rsp_o !== '0 || rsp_inf !== 1'b0 || rsp_neg !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: gnt=%b sq_ld=%b sq_a=%h rsp_vld=%b rsp_o=%h busy=%b required all zero",
               gnt, sq_ld, sq_a, rsp_vld, rsp_o, busy);
    end
    rst = 1'b0; rr_model = 0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || gnt !== '0) begin
      mismatched++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b required 0 0", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    req = '1;
    for (int k = 0; k < 5; k++) begin
      randomize_ops();
      core_delay = $urandom_range(1, 8);
      serve_one(0, 1'b0);
    end
    req = '0;
  endtask

  task automatic test_single();
    randomize_ops();
    req_a[2*128 +: 128] = FOUR;
    req = 4'b0100; core_delay = 3;
    serve_one(0, 1'b0);
    req = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      randomize_ops();
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      core_delay = $urandom_range(0, 8);
      serve_one($urandom_range(0, 3), 1'b0);
      req = '0;
    end
  endtask

  task automatic test_stale_done();
    core_stale = 1'b1; core_stale_len = MINLAT;
    req = 4'b0001;
    randomize_ops(); core_delay = 6;
    serve_one(0, 1'b0);
    randomize_ops(); core_delay = 2;
    serve_one(0, 1'b0);
    req = '0; core_stale = 1'b0;
  endtask

  task automatic test_back_to_back();
    randomize_ops();
    req = 4'b0011; core_delay = 5;
    serve_one(10, 1'b0);
    randomize_ops();
    serve_one(0, 1'b0);
    req = '0;
  endtask

  task automatic test_reset_mid();
    randomize_ops();
    req = 4'b0010; core_delay = 20;
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b1 || rsp_vld !== 1'b0) begin
      mismatched++;
      $display("FAIL in_wait: busy=%b rsp_vld=%b required 1 0", busy, rsp_vld);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (gnt !== '0 || sq_ld !== 1'b0 || sq_a !== '0 || sq_rm !== '0 || rsp_vld !== 1'b0 || rsp_id !== '0 ||
        rsp_o !== '0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: gnt=%b sq_ld=%b sq_a=%h rsp_vld=%b busy=%b required all zero",
               gnt, sq_ld, sq_a, rsp_vld, busy);
    end
    rst = 1'b0; rr_model = 0;
    randomize_ops();
    req = '1; core_delay = 2;
    serve_one(0, 1'b0);
    req = '0;
  endtask

  task automatic test_timeout();
    core_stuck0 = 1'b1;
    randomize_ops();
    req = 4'b0100;
`ifdef FP_SQRT_ARB_TIMEOUT_EN
    serve_one(0, 1'b1);
    req = '0;
`else
    begin
      bit bad;
      @(negedge clk);
      req = '0;
      bad = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (rsp_vld !== 1'b0 || busy !== 1'b1 || rsp_err !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL no_watchdog: response or idle seen with done stuck low, required rsp_vld=0 busy=1");
      end
      $display("txn id=2 stuck-done op held for 300 cycles without response");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rr_model = 0;
      @(negedge clk);
    end
`endif
    core_stuck0 = 1'b0;
  endtask

  initial begin
    req = '0; req_a = '0; req_rm = '0; rsp_rdy = 1'b1; rst = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_stale_done();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "time limit");
  end
endmodule
